dmem_arbiter: RTL and testbench

- Two-port arbiter in front of the single-port data memory (1-cycle registered read, write on the clock edge).
- Shares the memory between requester A (core load/store unit) and requester B (loader / debug DMA). Grants at most one access per cycle using round-robin.
- Supports locked sequences for atomic read-modify-write, with a lock watchdog.
- Returns read data one cycle after the grant.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arb_lock_timer.sv | 49 ++++
 rtl/dmem_arbiter.sv | 95 +++++++++
 tb/tb_dmem_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: requester ids and the request bundle.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_e;

    typedef struct packed {
        logic                  write;
        logic                  lock;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_arb_lock_timer.sv
// Lock ownership for atomic sequences, with a watchdog that forcibly releases
// an owner that sits idle for LOCK_TIMEOUT cycles and latches a sticky error.
module dmem_arb_lock_timer
    import dmem_arb_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic    CLK,
    input  logic    Reset_n,
    input  logic    gnt,
    input  req_id_e gnt_id,
    input  logic    gnt_lock,
    output logic    owner_vld,
    output req_id_e owner_id,
    output logic    timeout,
    output logic    LockErr
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // An owner grant in the expiry cycle takes precedence over the timeout.
    assign timeout = owner_vld && !gnt && (cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            owner_vld <= 1'b0;
            owner_id  <= REQ_A;
            cnt       <= '0;
            LockErr   <= 1'b0;
        end else if (gnt) begin
            // While locked only the owner can be granted, so Lock=0 here ends the sequence.
            owner_vld <= gnt_lock;
            owner_id  <= gnt_id;
            cnt       <= '0;
        end else if (owner_vld) begin
            if (timeout) begin
                owner_vld <= 1'b0;
                cnt       <= '0;
                LockErr   <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two requesters,
// with locked read-modify-write sequences and a one-cycle registered read return.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              A_Valid,
    output logic              A_Ready,
    input  logic              A_Write,
    input  logic              A_Lock,
    input  logic [ADDR_W-1:0] A_Addr,
    input  logic [DATA_W-1:0] A_WData,
    output logic              A_RValid,
    output logic [DATA_W-1:0] A_RData,
    input  logic              B_Valid,
    output logic              B_Ready,
    input  logic              B_Write,
    input  logic              B_Lock,
    input  logic [ADDR_W-1:0] B_Addr,
    input  logic [DATA_W-1:0] B_WData,
    output logic              B_RValid,
    output logic [DATA_W-1:0] B_RData,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic              Mem_ReadMem,
    output logic              Mem_WriteMem,
    output logic [DATA_W-1:0] Mem_DataIn,
    input  logic [DATA_W-1:0] Mem_DataOut,
    output logic              LockErr
);

    req_id_e  ptr, rsp_id, owner_id, gnt_id;
    logic     rsp_pend, owner_vld, timeout;
    logic     elig_a, elig_b, gnt_a, gnt_b, gnt;
    mem_req_t req_a, req_b, sel;

    assign req_a = '{write: A_Write, lock: A_Lock, addr: A_Addr, wdata: A_WData};
    assign req_b = '{write: B_Write, lock: B_Lock, addr: B_Addr, wdata: B_WData};

    // Reset_n gates eligibility so nothing reaches the memory while reset is held.
    assign elig_a = Reset_n && A_Valid && (!owner_vld || owner_id == REQ_A);
    assign elig_b = Reset_n && B_Valid && (!owner_vld || owner_id == REQ_B);
    assign gnt_a  = elig_a && (!elig_b || ptr == REQ_A);
    assign gnt_b  = elig_b && !gnt_a;
    assign gnt    = gnt_a || gnt_b;
    assign gnt_id = gnt_b ? REQ_B : REQ_A;
    assign sel    = gnt_b ? req_b : req_a;

    assign A_Ready      = gnt_a;
    assign B_Ready      = gnt_b;
    assign Mem_Address  = gnt ? sel.addr  : '0;
    assign Mem_DataIn   = gnt ? sel.wdata : '0;
    assign Mem_WriteMem = gnt &&  sel.write;
    assign Mem_ReadMem  = gnt && !sel.write;

    dmem_arb_lock_timer #(
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) u_lock (
        .CLK      (CLK),
        .Reset_n  (Reset_n),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_lock (sel.lock),
        .owner_vld(owner_vld),
        .owner_id (owner_id),
        .timeout  (timeout),
        .LockErr  (LockErr)
    );

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr      <= REQ_A;
            rsp_pend <= 1'b0;
            rsp_id   <= REQ_A;
        end else begin
            if (gnt)
                ptr <= gnt_b ? REQ_A : REQ_B;
            else if (timeout)
                ptr <= (owner_id == REQ_A) ? REQ_B : REQ_A;
            rsp_pend <= gnt && !sel.write;
            if (gnt)
                rsp_id <= gnt_id;
        end
    end

    assign A_RValid = rsp_pend && (rsp_id == REQ_A);
    assign B_RValid = rsp_pend && (rsp_id == REQ_B);
    assign A_RData  = A_RValid ? Mem_DataOut : '0;
    assign B_RData  = B_RValid ? Mem_DataOut : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter against a cycle-level reference model.
module tb_dmem_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int TMO = 4;

    logic          CLK = 1'b0;
    logic          Reset_n;
    logic          A_Valid, B_Valid, A_Write, B_Write, A_Lock, B_Lock;
    logic [AW-1:0] A_Addr, B_Addr;
    logic [DW-1:0] A_WData, B_WData;
    logic          A_Ready, B_Ready, A_RValid, B_RValid;
    logic [DW-1:0] A_RData, B_RData;
    logic [AW-1:0] Mem_Address;
    logic          Mem_ReadMem, Mem_WriteMem, LockErr;
    logic [DW-1:0] Mem_DataIn, Mem_DataOut;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_TIMEOUT(TMO)) dut (
        .CLK(CLK), .Reset_n(Reset_n),
        .A_Valid(A_Valid), .A_Ready(A_Ready), .A_Write(A_Write), .A_Lock(A_Lock),
        .A_Addr(A_Addr), .A_WData(A_WData), .A_RValid(A_RValid), .A_RData(A_RData),
        .B_Valid(B_Valid), .B_Ready(B_Ready), .B_Write(B_Write), .B_Lock(B_Lock),
        .B_Addr(B_Addr), .B_WData(B_WData), .B_RValid(B_RValid), .B_RData(B_RData),
        .Mem_Address(Mem_Address), .Mem_ReadMem(Mem_ReadMem), .Mem_WriteMem(Mem_WriteMem),
        .Mem_DataIn(Mem_DataIn), .Mem_DataOut(Mem_DataOut), .LockErr(LockErr)
    );

    always #5 CLK = ~CLK;

    // Physical memory seen by the DUT: 1-cycle registered read, write on the edge.
    logic [DW-1:0] env_mem [0:(1<<AW)-1];
    always @(posedge CLK) begin
        if (Mem_WriteMem) env_mem[Mem_Address] <= Mem_DataIn;
        if (Mem_ReadMem)  Mem_DataOut <= env_mem[Mem_Address];
    end

    // Reference model: owner = -1 when unlocked, idle counts owner cycles without a grant.
    typedef struct { int id; logic [DW-1:0] data; int due; } rsp_t;
    logic [DW-1:0]    ref_mem [0:(1<<AW)-1];
    rsp_t             rq[$];
    int               m_ptr, m_owner, m_idle;
    bit               m_err;
    logic             exp_ar, exp_br, exp_err;
    logic [AW+DW+1:0] exp_bus;
    int               cyc, n_chk, n_pass;
    bit               mon_en;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    function automatic void model_step();
        bit v[2], w[2], l[2];
        logic [AW-1:0] ad[2];
        logic [DW-1:0] wd[2];
        int win = -1;
        exp_ar = 1'b0; exp_br = 1'b0; exp_bus = '0; exp_err = m_err;
        if (!Reset_n) begin
            m_ptr = 0; m_owner = -1; m_idle = 0; m_err = 0; exp_err = 1'b0;
            rq.delete();
            return;
        end
        v[0] = A_Valid; w[0] = A_Write; l[0] = A_Lock; ad[0] = A_Addr; wd[0] = A_WData;
        v[1] = B_Valid; w[1] = B_Write; l[1] = B_Lock; ad[1] = B_Addr; wd[1] = B_WData;
        for (int i = 0; i < 2; i++) if (m_owner >= 0 && m_owner != i) v[i] = 0;
        if (v[0] && v[1]) win = m_ptr;
        else if (v[0]) win = 0;
        else if (v[1]) win = 1;
        if (win >= 0) begin
            exp_ar  = (win == 0);
            exp_br  = (win == 1);
            exp_bus = {ad[win], wd[win], !w[win], w[win]};
            m_ptr   = 1 - win;
            m_idle  = 0;
            if (w[win]) ref_mem[ad[win]] = wd[win];
            else rq.push_back('{win, ref_mem[ad[win]], cyc + 1});
            if (l[win]) m_owner = win;
            else if (m_owner == win) m_owner = -1;
        end else if (m_owner >= 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_ptr = 1 - m_owner; m_owner = -1; m_err = 1; m_idle = 0;
            end
        end
    endfunction

    // Monitor: compares the DUT against the expectations of the current cycle.
    always @(negedge CLK) begin
        rsp_t r;
        if (mon_en) begin
            chk("ready", 32'({A_Ready, B_Ready}), 32'({exp_ar, exp_br}));
            chk("membus", 32'({Mem_Address, Mem_DataIn, Mem_ReadMem, Mem_WriteMem}), 32'(exp_bus));
            chk("lockerr", 32'(LockErr), 32'(exp_err));
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                if (r.id == 0)
                    chk("a_rsp", 32'({A_RValid, B_RValid, A_RData, B_RData}),
                        32'({1'b1, 1'b0, r.data, {DW{1'b0}}}));
                else
                    chk("b_rsp", 32'({A_RValid, B_RValid, A_RData, B_RData}),
                        32'({1'b0, 1'b1, {DW{1'b0}}, r.data}));
            end else begin
                chk("no_rsp", 32'({A_RValid, B_RValid, A_RData, B_RData}), 32'd0);
            end
        end
    end

    task automatic tick();
        cyc++;
        model_step();
        mon_en = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_a(bit v, bit w, bit l, logic [AW-1:0] ad, logic [DW-1:0] wd);
        A_Valid = v; A_Write = w; A_Lock = l; A_Addr = ad; A_WData = wd;
    endtask

    task automatic set_b(bit v, bit w, bit l, logic [AW-1:0] ad, logic [DW-1:0] wd);
        B_Valid = v; B_Write = w; B_Lock = l; B_Addr = ad; B_WData = wd;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            env_mem[i] = DW'($urandom);
            ref_mem[i] = env_mem[i];
        end
        Mem_DataOut = '0;
        cyc = 0; n_chk = 0; n_pass = 0; mon_en = 1'b0;
        m_ptr = 0; m_owner = -1; m_idle = 0; m_err = 0;
        Reset_n = 1'b0;
        set_a(1, 0, 0, 8'h05, 8'h00);
        set_b(1, 0, 0, 8'h06, 8'h00);
        @(posedge CLK); #1;

        // Reset held with both requesters valid, then first contended grant
        repeat (3) tick();
        Reset_n = 1'b1;
        tick();

        // Write then read-back on A
        set_b(0, 0, 0, 8'h00, 8'h00);
        set_a(1, 1, 0, 8'h10, 8'hAB); tick();
        set_a(1, 0, 0, 8'h10, 8'h00); tick();
        set_a(0, 0, 0, 8'h00, 8'h00); tick();

        // Contention: continuous reads from both sides alternate
        set_a(1, 1, 0, 8'h01, 8'h11); tick();
        set_a(0, 0, 0, 8'h00, 8'h00);
        set_b(1, 1, 0, 8'h02, 8'h22); tick();
        set_a(1, 0, 0, 8'h01, 8'h00);
        set_b(1, 0, 0, 8'h02, 8'h00);
        repeat (6) tick();

        // Locked read-modify-write by B while A keeps requesting
        set_b(0, 0, 0, 8'h00, 8'h00);
        set_a(1, 0, 0, 8'h03, 8'h00); tick();
        set_a(1, 0, 0, 8'h20, 8'h00);
        set_b(1, 0, 1, 8'h20, 8'h00); tick();
        set_b(1, 1, 0, 8'h20, 8'h5A); tick();
        set_b(0, 0, 0, 8'h00, 8'h00); tick();
        set_a(0, 0, 0, 8'h00, 8'h00); tick();

        // Lock timeout: A locks then goes idle while B waits
        set_a(1, 0, 1, 8'h30, 8'h00); tick();
        set_a(0, 0, 0, 8'h00, 8'h00);
        set_b(1, 0, 0, 8'h31, 8'h00);
        repeat (7) tick();
        set_b(0, 0, 0, 8'h00, 8'h00);
        repeat (2) tick();

        // Random traffic on a small address window to exercise read-after-write
        repeat (400) begin
            set_a($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0,
                  AW'($urandom_range(0, 15)), DW'($urandom));
            set_b($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0,
                  AW'($urandom_range(0, 15)), DW'($urandom));
            tick();
        end

        // Asynchronous reset right after a locked A read grant
        set_a(0, 0, 0, 8'h00, 8'h00);
        set_b(0, 0, 0, 8'h00, 8'h00);
        repeat (TMO + 2) tick();
        set_a(1, 0, 1, 8'h05, 8'h00); tick();
        Reset_n = 1'b0;
        #1;
        chk("rst_async_rvalid", 32'({A_RValid, A_RData}), 32'd0);
        set_a(0, 0, 0, 8'h00, 8'h00);
        repeat (2) tick();
        Reset_n = 1'b1;
        set_b(1, 0, 0, 8'h07, 8'h00);
        repeat (2) tick();
        set_b(0, 0, 0, 8'h00, 8'h00);
        repeat (2) tick();

        if (rq.size() != 0) chk("rsp_drain", 32'(rq.size()), 32'd0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
